// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the result queue: IEEE exception status flags.
package fpnew_pkg;

  // IEEE 754 exception flags; packed order gives NV at bit 4 down to NX at bit 0.
  typedef struct packed {
    logic NV; // invalid operation
    logic DZ; // divide by zero
    logic OF; // overflow
    logic UF; // underflow
    logic NX; // inexact
  } status_t;

endpackage

// File: rtl/fpnew_result_fifo.sv
// In-order FIFO with registered occupancy counter and synchronous flush.
//
// Handshake: a beat transfers on the input side when in_valid && in_ready
// (and no flush), and on the output side when out_valid && out_ready.
// in_ready depends only on registered state. out_valid is the registered
// non-empty condition with a single gate from flush. The write side never
// falls through to the read side, and a full queue refuses a push even when a
// pop happens in the same cycle.
module fpnew_result_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned DataWidth = 74,
  parameter int unsigned Depth     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [DataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(Depth+1)-1:0]     count,
  output logic                           busy
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push;
  logic                 pop;

  assign in_ready  = (count_q != CntW'(Depth));
  assign out_valid = (count_q != '0) && !flush_i;
  assign push      = in_valid && in_ready && !flush_i;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_q];
  assign count     = count_q;
  assign busy      = (count_q != '0);

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/fpnew_result_queue.sv
// Result buffer between FPU output and core writeback, with sticky fflags.
//
// Handshake: upstream transfers on fpu_valid_i && fpu_ready_o (dropped during
// flush); downstream transfers on wb_valid_o && wb_ready_i. fpu_ready_o comes
// from registered occupancy only, so there is no path from wb_ready_i to it.
module fpnew_result_queue
  import fpnew_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 5,
  parameter int unsigned Depth    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [Width-1:0]             fpu_result_i,
  input  logic [4:0]                   fpu_status_i,
  input  logic [TagWidth-1:0]          fpu_tag_i,
  input  logic                         fpu_valid_i,
  output logic                         fpu_ready_o,
  output logic [Width-1:0]             wb_result_o,
  output logic [4:0]                   wb_status_o,
  output logic [TagWidth-1:0]          wb_tag_o,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  input  logic                         fflags_clr_i,
  output logic [4:0]                   fflags_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         busy_o
);

  typedef struct packed {
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t  in_entry;
  entry_t  head;
  status_t fflags_q;
  logic    pop;

  assign in_entry.result = fpu_result_i;
  assign in_entry.status = status_t'(fpu_status_i);
  assign in_entry.tag    = fpu_tag_i;

  fpnew_result_fifo #(
    .DataWidth ($bits(entry_t)),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .in_data   (in_entry),
    .in_valid  (fpu_valid_i),
    .in_ready  (fpu_ready_o),
    .out_data  (head),
    .out_valid (wb_valid_o),
    .out_ready (wb_ready_i),
    .count     (count_o),
    .busy      (busy_o)
  );

  assign wb_result_o = head.result;
  assign wb_status_o = head.status;
  assign wb_tag_o    = head.tag;
  assign pop         = wb_valid_o && wb_ready_i;
  assign fflags_o    = fflags_q;

  // Sticky flag accumulation over consumed results; a clear racing a pop keeps the popped flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else if (pop) begin
      fflags_q <= (fflags_clr_i ? status_t'('0) : fflags_q) | head.status;
    end else if (fflags_clr_i) begin
      fflags_q <= '0;
    end
  end

endmodule

// File: tb/tb_fpnew_result_queue.sv
// Self-checking bench for fpnew_result_queue: vector table, hand sequences, scoreboard.
module tb_fpnew_result_queue;

  localparam int W_RES = 64;
  localparam int W_TAG = 5;
  localparam int DEPTH = 4;
  localparam int W     = W_RES + 5 + W_TAG;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [W_RES-1:0] fpu_result = '0;
  logic [4:0]       fpu_status = '0;
  logic [W_TAG-1:0] fpu_tag = '0;
  logic             fpu_valid = 1'b0;
  logic             fpu_ready;
  logic [W_RES-1:0] wb_result;
  logic [4:0]       wb_status;
  logic [W_TAG-1:0] wb_tag;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic             fflags_clr = 1'b0;
  logic [4:0]       fflags;
  logic [2:0]       count;
  logic             busy;

  fpnew_result_queue #(.Width(W_RES), .TagWidth(W_TAG), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .fpu_result_i (fpu_result),
    .fpu_status_i (fpu_status),
    .fpu_tag_i    (fpu_tag),
    .fpu_valid_i  (fpu_valid),
    .fpu_ready_o  (fpu_ready),
    .wb_result_o  (wb_result),
    .wb_status_o  (wb_status),
    .wb_tag_o     (wb_tag),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .fflags_clr_i (fflags_clr),
    .fflags_o     (fflags),
    .count_o      (count),
    .busy_o       (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard state: expected entries {result, status, tag} and a reference model
  logic [W-1:0] exp_q[$];
  int           m_count = 0;
  logic [4:0]   m_fflags = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Driver: one cycle of stimulus, with model update and checks on both sides of the edge
  task automatic step(input logic v, input logic [W_TAG-1:0] tg, input logic [4:0] st,
                      input logic wr, input logic fl, input logic cl);
    logic         m_wbv;
    logic         do_push;
    logic         do_pop;
    logic [W-1:0] e;
    @(negedge clk);
    fpu_valid  = v;
    fpu_tag    = tg;
    fpu_status = st;
    fpu_result = {$urandom, $urandom};
    wb_ready   = wr;
    flush      = fl;
    fflags_clr = cl;
    #1;
    m_wbv   = (m_count != 0) && !fl;
    do_pop  = m_wbv && wr;
    do_push = v && (m_count != DEPTH) && !fl;
    check("wb_valid", W'(wb_valid), W'(m_wbv));
    check("fpu_ready", W'(fpu_ready), W'(m_count != DEPTH));
    if (do_pop) begin
      e = exp_q.pop_front();
      check("wb_head", {wb_result, wb_status, wb_tag}, e);
      m_fflags = (cl ? 5'h00 : m_fflags) | e[W_TAG +: 5];
    end else if (cl) begin
      m_fflags = 5'h00;
    end
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (do_push) exp_q.push_back({fpu_result, st, tg});
      m_count = m_count + int'(do_push) - int'(do_pop);
    end
    @(posedge clk);
    #1;
    check("count", W'(count), W'(m_count));
    check("busy", W'(busy), W'(m_count != 0));
    check("fflags", W'(fflags), W'(m_fflags));
  endtask

  task automatic do_reset(input logic hold_valid);
    @(negedge clk);
    rst = 1'b1;
    fpu_valid = hold_valid;
    wb_ready = 1'b1;
    flush = 1'b0;
    fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fpu_valid = 1'b0;
    wb_ready = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_fflags = '0;
    #1;
    check("rst_ready", W'(fpu_ready), W'(1));
    check("rst_wb_valid", W'(wb_valid), W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_fflags", W'(fflags), W'(0));
  endtask

  typedef struct {
    logic             v;
    logic [W_TAG-1:0] tg;
    logic [4:0]       st;
    logic             wr;
    logic             fl;
    logic             cl;
    int               exp_count;
    logic [4:0]       exp_fflags;
  } vec_t;

  vec_t vecs[26];

  initial begin
    // fill 1..4, held-off fifth push, drain in order
    vecs[0]  = '{1, 5'd1,  5'h01, 0, 0, 0, 1, 5'h00};
    vecs[1]  = '{1, 5'd2,  5'h02, 0, 0, 0, 2, 5'h00};
    vecs[2]  = '{1, 5'd3,  5'h04, 0, 0, 0, 3, 5'h00};
    vecs[3]  = '{1, 5'd4,  5'h08, 0, 0, 0, 4, 5'h00};
    vecs[4]  = '{1, 5'd5,  5'h10, 0, 0, 0, 4, 5'h00};
    vecs[5]  = '{0, 5'd0,  5'h00, 1, 0, 0, 3, 5'h01};
    vecs[6]  = '{0, 5'd0,  5'h00, 1, 0, 0, 2, 5'h03};
    vecs[7]  = '{0, 5'd0,  5'h00, 1, 0, 0, 1, 5'h07};
    vecs[8]  = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h0F};
    vecs[9]  = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h0F};
    // clear race: clear, then build 5'h10, pop 5'h01 with clear, plain clear
    vecs[10] = '{0, 5'd0,  5'h00, 0, 0, 1, 0, 5'h00};
    vecs[11] = '{1, 5'd6,  5'h10, 0, 0, 0, 1, 5'h00};
    vecs[12] = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h10};
    vecs[13] = '{1, 5'd7,  5'h01, 0, 0, 0, 1, 5'h10};
    vecs[14] = '{0, 5'd0,  5'h00, 1, 0, 1, 0, 5'h01};
    vecs[15] = '{0, 5'd0,  5'h00, 0, 0, 1, 0, 5'h00};
    // flush with count=3 alongside push and pop requests; flags survive
    vecs[16] = '{0, 5'd0,  5'h00, 0, 0, 0, 0, 5'h00};
    vecs[17] = '{1, 5'd8,  5'h04, 1, 0, 0, 1, 5'h00};
    vecs[18] = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h04};
    vecs[19] = '{1, 5'd9,  5'h08, 0, 0, 0, 1, 5'h04};
    vecs[20] = '{1, 5'd10, 5'h10, 0, 0, 0, 2, 5'h04};
    vecs[21] = '{1, 5'd11, 5'h02, 0, 0, 0, 3, 5'h04};
    vecs[22] = '{1, 5'd12, 5'h01, 1, 1, 0, 0, 5'h04};
    vecs[23] = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h04};
    vecs[24] = '{1, 5'd13, 5'h02, 0, 0, 0, 1, 5'h04};
    vecs[25] = '{0, 5'd0,  5'h00, 1, 0, 0, 0, 5'h06};

    do_reset(1'b1);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].v, vecs[i].tg, vecs[i].st, vecs[i].wr, vecs[i].fl, vecs[i].cl);
      check($sformatf("vec%0d_count", i), W'(count), W'(vecs[i].exp_count));
      check($sformatf("vec%0d_fflags", i), W'(fflags), W'(vecs[i].exp_fflags));
    end

    // streaming: one push per cycle, head consumed each cycle, occupancy stays 1
    step(1, 5'd16, 5'(($urandom_range(0, 31))), 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 5'(17 + i), 5'($urandom_range(0, 31)), 1, 0, 0);
      check("stream_count", W'(count), W'(1));
    end
    step(0, 5'd0, 5'h00, 1, 0, 0);
    check("stream_drained", W'(count), W'(0));

    // full with simultaneous pop: push refused, then accepted with count steady
    for (int i = 0; i < 4; i++) step(1, 5'(20 + i), 5'($urandom_range(0, 31)), 0, 0, 0);
    check("full_count", W'(count), W'(4));
    step(1, 5'd24, 5'h03, 1, 0, 0);
    check("full_pop_refused", W'(count), W'(3));
    step(1, 5'd25, 5'h05, 1, 0, 0);
    check("full_pop_accept", W'(count), W'(3));
    for (int i = 0; i < 3; i++) step(0, 5'd0, 5'h00, 1, 0, 0);
    check("full_drained", W'(count), W'(0));

    // random traffic against the model
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));

    // reset overrides push/pop with entries buffered
    step(1, 5'd30, 5'h1F, 0, 0, 0);
    step(1, 5'd31, 5'h1F, 0, 0, 0);
    do_reset(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
